// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter with line-break support. Accepts one word per
// valid/ready handshake and serialises it as start bit, DATA_BITS data bits
// (LSB first), an optional parity bit and STOP_BITS stop bits, each exactly
// TICKS clock cycles long. A break request holds the line low for at least
// one frame length, followed by one bit period of mark before returning idle.
//
// Parameters:
//   CLK_HZ     input clock frequency in Hz
//   BAUD       line rate in bit/s, TICKS = round(CLK_HZ / BAUD), TICKS >= 2
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset_n     asynchronous active-low reset (release synchronised inside)
//   data        word to send, sampled on the accept edge
//   data_valid  producer has a word
//   ready       transmitter can accept (transfer on data_valid && ready)
//   break_req   request to hold the line low (break)
//   busy        frame or break in progress, always the inverse of ready
//   uart_tx     serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_param #(
   parameter int CLK_HZ    = 12000000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 data_valid,
   output logic                 ready,
   input  logic                 break_req,
   output logic                 busy,
   output logic                 uart_tx
);

   localparam int TICKS      = (BAUD > 0) ? ((CLK_HZ + BAUD / 2) / BAUD) : 0;
   localparam int CNT_W      = (TICKS > 2) ? $clog2(TICKS) : 1;
   localparam int PAR_BITS   = (PARITY != 0) ? 1 : 0;
   localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

   localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICKS - 1);
   localparam logic [CNT_W-1:0] TICK_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TICK_ZERO  = {CNT_W{1'b0}};
   localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
   localparam logic [3:0]       FRAME_LAST = 4'(FRAME_BITS - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_START    = 3'd1;
   localparam logic [2:0] ST_DATA     = 3'd2;
   localparam logic [2:0] ST_PARITY   = 3'd3;
   localparam logic [2:0] ST_STOP     = 3'd4;
   localparam logic [2:0] ST_BREAK    = 3'd5;
   localparam logic [2:0] ST_BRK_MARK = 3'd6;

   // Parameter legality is checked while elaborating, not at run time.
   if (TICKS < 2) begin : g_bad_ticks
      $error("uart_tx_param: (CLK_HZ + BAUD/2) / BAUD must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end

   // Parity of the latched word: even mode sends the XOR, odd mode its inverse.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
      logic x;
      x = ^word;
      if (PARITY == 1) begin
         parity_bit = ~x;
      end else begin
         parity_bit = x;
      end
   endfunction

   logic [1:0]           rst_sync_r;
   logic                 rst_int_n_s;
   logic [2:0]           state_r;
   logic [CNT_W-1:0]     tick_r;
   logic [3:0]           bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_r;
   logic                 tx_r;
   logic                 ready_r;
   logic                 busy_r;
   logic                 tick_zero_s;
   logic                 bit_zero_s;

   // Reset synchroniser: asserts immediately with reset_n, releases two edges later.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_int_n_s = rst_sync_r[1];
   assign tick_zero_s = (tick_r == TICK_ZERO);
   assign bit_zero_s  = (bit_cnt_r == 4'd0);

   // Transmit sequencer: bit timing, shifting, parity, break and handshake flags.
   always_ff @(posedge clock or negedge rst_int_n_s) begin
      if (!rst_int_n_s) begin
         state_r   <= ST_IDLE;
         tick_r    <= TICK_ZERO;
         bit_cnt_r <= 4'd0;
         shift_r   <= {DATA_BITS{1'b0}};
         par_r     <= 1'b0;
         tx_r      <= 1'b1;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // data_valid wins over break_req; the start bit begins on this edge.
               if (data_valid) begin
                  shift_r <= data;
                  par_r   <= parity_bit(data);
                  tx_r    <= 1'b0;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  tick_r  <= TICK_LAST;
                  state_r <= ST_START;
               end else if (break_req) begin
                  // The break lasts at least FRAME_BITS bit periods.
                  tx_r      <= 1'b0;
                  ready_r   <= 1'b0;
                  busy_r    <= 1'b1;
                  tick_r    <= TICK_LAST;
                  bit_cnt_r <= FRAME_LAST;
                  state_r   <= ST_BREAK;
               end else begin
                  tx_r    <= 1'b1;
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  tick_r  <= TICK_ZERO;
               end
            end

            ST_START: begin
               if (tick_zero_s) begin
                  tx_r      <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                  bit_cnt_r <= DATA_LAST;
                  tick_r    <= TICK_LAST;
                  state_r   <= ST_DATA;
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            ST_DATA: begin
               // bit_cnt_r holds the number of data bits still to follow.
               if (tick_zero_s) begin
                  tick_r <= TICK_LAST;
                  if (!bit_zero_s) begin
                     tx_r      <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                     bit_cnt_r <= bit_cnt_r - 4'd1;
                  end else if (PARITY != 0) begin
                     tx_r    <= par_r;
                     state_r <= ST_PARITY;
                  end else begin
                     tx_r      <= 1'b1;
                     bit_cnt_r <= STOP_LAST;
                     state_r   <= ST_STOP;
                  end
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            ST_PARITY: begin
               if (tick_zero_s) begin
                  tx_r      <= 1'b1;
                  bit_cnt_r <= STOP_LAST;
                  tick_r    <= TICK_LAST;
                  state_r   <= ST_STOP;
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            ST_STOP: begin
               if (tick_zero_s) begin
                  if (!bit_zero_s) begin
                     bit_cnt_r <= bit_cnt_r - 4'd1;
                     tick_r    <= TICK_LAST;
                  end else begin
                     ready_r <= 1'b1;
                     busy_r  <= 1'b0;
                     tick_r  <= TICK_ZERO;
                     state_r <= ST_IDLE;
                  end
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            ST_BREAK: begin
               // Once the minimum has elapsed the counter parks at zero until
               // break_req falls.
               if (tick_zero_s) begin
                  if (!bit_zero_s) begin
                     bit_cnt_r <= bit_cnt_r - 4'd1;
                     tick_r    <= TICK_LAST;
                  end else if (!break_req) begin
                     tx_r    <= 1'b1;
                     tick_r  <= TICK_LAST;
                     state_r <= ST_BRK_MARK;
                  end else begin
                     tick_r <= TICK_ZERO;
                  end
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            ST_BRK_MARK: begin
               if (tick_zero_s) begin
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  tick_r  <= TICK_ZERO;
                  state_r <= ST_IDLE;
               end else begin
                  tick_r <= tick_r - TICK_ONE;
               end
            end

            default: begin
               state_r <= ST_IDLE;
               tick_r  <= TICK_ZERO;
               tx_r    <= 1'b1;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx = tx_r;
   assign ready   = ready_r;
   assign busy    = busy_r;

endmodule
